// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready word handshake between a byte source and the UART transmitter
interface uart_tx_if #(parameter int DATA_BITS = 8);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;
  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_ser.sv
// uart_tx_ser: UART frame serializer (start, data LSB first, optional even parity, stop); falling-edge clocked.
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx_ser #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy,
  output logic     tx_done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic par;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t               state, state_n;
  logic [BW-1:0]        baud, baud_n;
  logic [CW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 tx_n, last;
  assign last         = baud == BAUD_LAST;
  assign bus.tx_ready = state == IDLE;
  assign busy         = state != IDLE;
  assign tx_done      = state == STOP && last;
  always_ff @(negedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      baud    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_cnt <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
`ifdef UART_TX_PARITY_EN
  always_ff @(negedge clk or negedge rst)
    if (!rst) par <= 1'b0;
    else if (state == IDLE && bus.tx_valid) par <= ^bus.tx_data;
`endif
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    shift_n = shift;
    baud_n  = (state == IDLE || last) ? '0 : baud + 1'b1;
    unique case (state)
      IDLE:
        if (bus.tx_valid) begin
          state_n = START;
          shift_n = bus.tx_data;
        end
      START: state_n = last ? DATA : START;
      DATA:
        if (last) begin
          shift_n = shift >> 1;
          bit_n   = bit_cnt == BIT_LAST ? '0 : bit_cnt + 1'b1;
`ifdef UART_TX_PARITY_EN
          state_n = bit_cnt == BIT_LAST ? PARITY : DATA;
`else
          state_n = bit_cnt == BIT_LAST ? STOP : DATA;
`endif
        end
`ifdef UART_TX_PARITY_EN
      PARITY: state_n = last ? STOP : PARITY;
`endif
      STOP: state_n = last ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
    // tx is registered from the next state so the start bit appears on the accept edge
    tx_n = 1'b1;
    if (state_n == START) tx_n = 1'b0;
    else if (state_n == DATA) tx_n = shift_n[0];
`ifdef UART_TX_PARITY_EN
    else if (state_n == PARITY) tx_n = par;
`endif
  end
endmodule

// File: tb/tb_uart_tx_ser.sv
// tb_uart_tx_ser: randomized self-checking bench for uart_tx_ser against a frame-level bit model
module tb_uart_tx_ser;
  localparam int C = 4;
  localparam int D = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = D + 3;
`else
  localparam int NB = D + 2;
`endif
  logic clk = 1'b1;
  logic rst = 1'b0;
  logic tx, busy, tx_done;
  int checks = 0;
  int passed = 0;
  uart_tx_if #(.DATA_BITS(D)) ifc ();
  uart_tx_ser #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
    .clk(clk), .rst(rst), .bus(ifc.slave), .tx(tx), .busy(busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;

  function automatic logic exp_bit(input logic [D-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= D) return d[k-1];
    if (k == D + 1 && NB == D + 3) return ^d;
    return 1'b1;
  endfunction

  task automatic start_frame(input logic [D-1:0] d);
    int n = 0;
    while (ifc.tx_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 200) $display("FAIL start_timeout: tx_ready=%b required 1", ifc.tx_ready);
    else passed++;
    ifc.tx_valid = 1'b1;
    ifc.tx_data  = d;
    @(posedge clk);
  endtask

  task automatic check_frame(input string name, input logic [D-1:0] d, input logic [D-1:0] nxt, input logic vld);
    logic [3:0] got, exp;
    ifc.tx_data  = nxt;
    ifc.tx_valid = vld;
    for (int i = 0; i < NB * C; i++) begin
      got = {tx, busy, ifc.tx_ready, tx_done};
      exp = {exp_bit(d, i / C), 1'b1, 1'b0, i == NB * C - 1};
      checks++;
      if (got !== exp) $display("FAIL %s cyc%0d {tx,busy,ready,done}=%b required %b", name, i, got, exp);
      else passed++;
      @(posedge clk);
    end
    got = {tx, busy, ifc.tx_ready, tx_done};
    checks++;
    if (got !== 4'b1010) $display("FAIL %s idle_after {tx,busy,ready,done}=%b required 1010", name, got);
    else passed++;
  endtask

  task automatic test_reset;
    logic [3:0] got;
    int bad = 0;
    rst = 1'b0;
    ifc.tx_valid = 1'b0;
    ifc.tx_data  = '0;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      got = {tx, busy, ifc.tx_ready, tx_done};
      checks++;
      if (got !== 4'b1010) $display("FAIL reset_idle cyc%0d {tx,busy,ready,done}=%b required 1010", i, got);
      else passed++;
    end
  endtask

  task automatic test_single;
    start_frame(8'hA5);
    check_frame("single_a5", 8'hA5, 8'h00, 1'b0);
  endtask

  task automatic test_random;
    logic [D-1:0] d;
    for (int f = 0; f < 20; f++) begin
      d = D'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      start_frame(d);
      check_frame("random", d, D'($urandom), 1'b0);
    end
  endtask

  task automatic test_back_to_back;
    start_frame(8'h00);
    check_frame("b2b_first", 8'h00, 8'hFF, 1'b1);
    @(posedge clk);
    check_frame("b2b_second", 8'hFF, 8'h00, 1'b0);
  endtask

  task automatic test_data_change;
    start_frame(8'h3C);
    check_frame("data_change", 8'h3C, 8'hC3, 1'b0);
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] got;
    start_frame(8'h00);
    ifc.tx_valid = 1'b0;
    repeat (12) @(posedge clk);
    got = {tx, busy, ifc.tx_ready, tx_done};
    checks++;
    if (got !== 4'b0100) $display("FAIL pre_reset {tx,busy,ready,done}=%b required 0100", got);
    else passed++;
    rst = 1'b0;
    #1;
    got = {tx, busy, ifc.tx_ready, tx_done};
    checks++;
    if (got !== 4'b1010) $display("FAIL async_reset {tx,busy,ready,done}=%b required 1010", got);
    else passed++;
    repeat (2) @(posedge clk);
    rst = 1'b1;
    start_frame(8'h81);
    check_frame("after_reset_81", 8'h81, 8'h00, 1'b0);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    start_frame(8'h07);
    checks++;
    if (NB * C != 44) $display("FAIL parity_len frame=%0d required 44", NB * C);
    else passed++;
    check_frame("parity_07", 8'h07, 8'h00, 1'b0);
    start_frame(8'h03);
    check_frame("parity_03", 8'h03, 8'h00, 1'b0);
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_random;
    test_back_to_back;
    test_data_change;
    test_reset_mid_frame;
`ifdef UART_TX_PARITY_EN
    test_parity;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_ser.md
Name: uart_tx_ser

Overview:
Parallel-in, bit-serial-out UART-style frame transmitter. It is the sending end of the team's serial byte link.
- Accepts one data word through a valid/ready handshake.
- Emits start bit, data bits LSB first, optional parity bit, then stop bit.
- Holds each bit for a fixed number of clock cycles.
- Sits between the core's byte source and the board-level TX pin.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range ≥ 2; internal counter width $clog2(CLKS_PER_BIT)
DATA_BITS, 8, data bits per frame; legal range 5..9

Ports:
clk  input  1  system clock; all flops update on the falling edge
rst  input  1  reset, asynchronous, active-low
tx_valid  input  1  source presents a word on tx_data
tx_data  input  DATA_BITS  word to transmit; sampled only at handshake
tx_ready  output  1  high only in IDLE; word accepted when tx_valid && tx_ready at a clk falling edge
tx  output  1  serial line; idle level 1
busy  output  1  high from the accept edge through the last stop-bit cycle
tx_done  output  1  one-cycle pulse on the last cycle of the stop bit

Behaviour:
- Reset (rst=0, asynchronous):
  - tx=1, tx_ready=1, busy=0, tx_done=0.
  - State returns to IDLE; bit counter, baud counter and shift register are cleared.
  - Reset mid-frame aborts the frame immediately: tx returns to 1 without waiting for a clock edge.
  - After rst releases, the first accept is possible on the next falling edge.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE:
  - tx=1, tx_ready=1.
  - On handshake: latch tx_data into the shift register, baud counter=0, move to START.
- START:
  - tx=0 for exactly CLKS_PER_BIT cycles.
  - tx goes low on the accept edge itself, so no idle gap follows the handshake.
- DATA:
  - tx=shift[0] for CLKS_PER_BIT cycles; then shift right and increment the bit counter.
  - After DATA_BITS bits, go to PARITY if enabled, else STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - tx_done=1 on the final cycle; the next edge returns to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in each bit state.
  - Wraps to 0 at every bit boundary.
- Frame length from accept edge to IDLE: (2+DATA_BITS[+1 parity])*CLKS_PER_BIT cycles.
- Back-to-back frames:
  - If tx_valid is held high, the next accept occurs in the single IDLE cycle after STOP.
  - This gives exactly one idle-high cycle between frames.
- Input handling:
  - tx_valid while busy is ignored; the source must hold it until the handshake.
  - Changes on tx_data while busy have no effect on the frame in flight.
- X or glitch on tx_valid outside IDLE has no effect.
- tx is driven directly from a flop; no combinational path from inputs to tx.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA.
  - tx = even parity (XOR of the latched word) for CLKS_PER_BIT cycles.
  - Frame length grows by CLKS_PER_BIT.
- Undefined:
  - No PARITY state and no parity logic.
  - DATA transitions directly to STOP.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, then release, no valid → tx=1, tx_ready=1, busy=0 and tx_done=0 throughout 50 cycles.
- Single frame: CLKS_PER_BIT=4, DATA_BITS=8, send 0xA5 → tx sequence, 4 cycles per bit: 0 then 1,0,1,0,0,1,0,1 then 1.
  - tx_done pulses once, 40 cycles after accept.
  - tx_ready is low for exactly 40 cycles.
- Back-to-back: tx_valid held high with 0x00 then 0xFF → second start bit begins exactly one idle-high cycle after the first stop bit ends; both payloads are correct.
- Data change mid-frame: accept 0x3C, then drive tx_data=0xC3 during DATA → line still carries 0x3C.
- Reset mid-frame: assert rst at cycle 13 of a 0x00 frame → tx=1 before the next clock edge.
  - After release, a new frame of 0x81 transmits cleanly.
- Parity (UART_TX_PARITY_EN defined): send 0x07 → parity bit=1; send 0x03 → parity bit=0.
  - Frame length is 44 cycles at CLKS_PER_BIT=4.
